// File: rtl/bus_bridge_mc.sv
// CPU-to-peripheral bridge: decodes one CPU access against NUM_SLV address windows,
// forwards it to a single slave and completes it with a ready/error response.
module bus_bridge_mc #(
    parameter int                      NUM_SLV = 6,
    parameter int                      DATA_W  = 32,
    parameter logic [32*NUM_SLV-1:0]   BASE    = {NUM_SLV{32'h0}},
    parameter logic [32*NUM_SLV-1:0]   MASK    = {NUM_SLV{32'hFFFFF000}},
    parameter int                      TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_req,
    input  logic [31:0]               cpu_addr,
    input  logic                      cpu_wen,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_ready,
    output logic                      cpu_err,
    output logic [NUM_SLV-1:0]        slv_sel,
    output logic [31:0]               slv_addr,
    output logic                      slv_wen,
    output logic [DATA_W-1:0]         slv_wdata,
    input  logic [NUM_SLV*DATA_W-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]        slv_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0]        TO_LIMIT = 8'(TIMEOUT);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    state_t              state;
    logic [7:0]          cnt;
    logic                hit;
    logic [NUM_SLV-1:0]  hit_oh;
    logic [31:0]         hit_base;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;

    // Scan from the top index down so the lowest matching window overrides the rest.
    always_comb begin
        hit      = 1'b0;
        hit_oh   = '0;
        hit_base = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((cpu_addr & MASK[32*i +: 32]) == (BASE[32*i +: 32] & MASK[32*i +: 32])) begin
                hit       = 1'b1;
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit_base  = BASE[32*i +: 32];
            end
        end
    end

    // slv_sel is one-hot, so masking with it both picks and ignores unselected slaves.
    always_comb begin
        sel_ready = |(slv_ready & slv_sel);
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (slv_sel[i]) begin
                sel_rdata = sel_rdata | slv_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            slv_sel   <= '0;
            slv_wen   <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    if (cpu_req) begin
                        slv_wdata <= cpu_wdata;
                        if (hit) begin
                            slv_sel  <= hit_oh;
                            slv_addr <= cpu_addr - hit_base;
                            slv_wen  <= cpu_wen;
                            cnt      <= '0;
                            state    <= ACCESS;
                        end else begin
                            cpu_ready <= 1'b1;
                            cpu_err   <= 1'b1;
                            cpu_rdata <= '0;
                            state     <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // A ready in the final wait cycle is checked first, so it beats the timeout.
                    if (sel_ready) begin
                        cpu_rdata <= slv_wen ? '0 : sel_rdata;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b0;
                        slv_sel   <= '0;
                        slv_wen   <= 1'b0;
                        state     <= RESP;
                    end else if (cnt + 8'd1 == TO_LIMIT) begin
                        cpu_rdata <= ERR_DATA;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        slv_sel   <= '0;
                        slv_wen   <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_bridge_mc.sv
// Directed bench for bus_bridge_mc: cycle-exact checks of decode, wait states,
// miss, timeout, overlap priority, ready/timeout tie and mid-access reset.
module tb_bus_bridge_mc;

    localparam int NUM_SLV = 6;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    // slave:                   5             4             3             2             1             0
    localparam logic [32*NUM_SLV-1:0] BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000,
                                              32'hFFFF_F000, 32'h1000_0000, 32'h0000_4000};
    localparam logic [32*NUM_SLV-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFF00_0000,
                                              32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_F000};

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      cpu_req;
    logic [31:0]               cpu_addr;
    logic                      cpu_wen;
    logic [DATA_W-1:0]         cpu_wdata;
    logic [DATA_W-1:0]         cpu_rdata;
    logic                      cpu_ready;
    logic                      cpu_err;
    logic [NUM_SLV-1:0]        slv_sel;
    logic [31:0]               slv_addr;
    logic                      slv_wen;
    logic [DATA_W-1:0]         slv_wdata;
    logic [NUM_SLV*DATA_W-1:0] slv_rdata;
    logic [NUM_SLV-1:0]        slv_ready;

    int checks = 0;
    int errors = 0;
    int wen_cycles = 0;
    int write_cnt  = 0;
    int ready_cnt  = 0;
    logic [DATA_W-1:0] exp_q[$];

    bus_bridge_mc #(
        .NUM_SLV(NUM_SLV), .DATA_W(DATA_W), .BASE(BASE), .MASK(MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .slv_sel(slv_sel), .slv_addr(slv_addr), .slv_wen(slv_wen), .slv_wdata(slv_wdata),
        .slv_rdata(slv_rdata), .slv_ready(slv_ready)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_req(input logic [31:0] addr, input logic wen,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata);
        cpu_req   = 1'b1;
        cpu_addr  = addr;
        cpu_wen   = wen;
        cpu_wdata = wdata;
        exp_q.push_back(exp_rdata);
    endtask

    task automatic set_rdata(input int idx, input logic [31:0] d);
        slv_rdata[DATA_W*idx +: DATA_W] = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sel"},   32'(slv_sel), 32'h0);
        check({tag, "_wen"},   32'(slv_wen), 32'h0);
        check({tag, "_ready"}, 32'(cpu_ready), 32'h0);
        check({tag, "_err"},   32'(cpu_err), 32'h0);
        check({tag, "_rdata"}, cpu_rdata, 32'h0);
        check({tag, "_addr"},  slv_addr, 32'h0);
        check({tag, "_wdata"}, slv_wdata, 32'h0);
    endtask

    // Activity monitors: values seen at posedge are those of the cycle just ending.
    always @(posedge clk) begin
        if (slv_wen) wen_cycles++;
        if (slv_wen && ((slv_sel & slv_ready) != '0)) write_cnt++;
        if (cpu_ready) ready_cnt++;
    end

    // Scoreboard: every completion pops the read data expected for that request.
    always @(negedge clk) begin
        if (rst_n && cpu_ready) begin
            if (exp_q.size() > 0) check("sb_rdata", cpu_rdata, exp_q.pop_front());
            else                  check("sb_extra_ready", 32'(cpu_ready), 32'h0);
        end
    end

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_wen = 1'b0; cpu_wdata = '0;
        slv_rdata = '0; slv_ready = '0;
        cycle(2);
        check_idle_outputs("rst");
        rst_n = 1'b1;
        cycle(1);

        // Zero-wait read on slave 2
        slv_ready = 6'b000100;
        set_rdata(2, 32'h00A5_00A5);
        start_req(32'hFFFF_F070, 1'b0, 32'h0, 32'h00A5_00A5);
        cycle(1);
        check("zw_sel", 32'(slv_sel), 32'h04);
        check("zw_addr", slv_addr, 32'h70);
        check("zw_ready_c1", 32'(cpu_ready), 32'h0);
        cycle(1);
        check("zw_ready_c2", 32'(cpu_ready), 32'h1);
        check("zw_err", 32'(cpu_err), 32'h0);
        check("zw_rdata", cpu_rdata, 32'h00A5_00A5);
        check("zw_sel_drop", 32'(slv_sel), 32'h0);
        cpu_req = 1'b0; slv_ready = '0;
        cycle(1);
        check("zw_pulse_end", 32'(cpu_ready), 32'h0);

        // Wait-state write on slave 0: ready in the third ACCESS cycle
        wen_cycles = 0; write_cnt = 0; ready_cnt = 0;
        start_req(32'h0000_4010, 1'b1, 32'h1234, 32'h0);
        cycle(1);
        check("wr_sel", 32'(slv_sel), 32'h01);
        check("wr_addr", slv_addr, 32'h10);
        check("wr_wdata", slv_wdata, 32'h1234);
        check("wr_wen_c1", 32'(slv_wen), 32'h1);
        cycle(2);
        check("wr_ready_c3", 32'(cpu_ready), 32'h0);
        slv_ready = 6'b000001;
        cycle(1);
        check("wr_ready_c4", 32'(cpu_ready), 32'h1);
        check("wr_err", 32'(cpu_err), 32'h0);
        check("wr_wen_off", 32'(slv_wen), 32'h0);
        cpu_req = 1'b0; slv_ready = '0;
        cycle(2);
        check("wr_wen_cycles", 32'(wen_cycles), 32'd3);
        check("wr_write_cnt", 32'(write_cnt), 32'd1);
        check("wr_ready_pulses", 32'(ready_cnt), 32'd1);

        // Decode miss
        slv_ready = 6'b111111;
        start_req(32'h8000_0000, 1'b0, 32'h0, 32'h0);
        cycle(1);
        check("miss_sel", 32'(slv_sel), 32'h0);
        check("miss_ready", 32'(cpu_ready), 32'h1);
        check("miss_err", 32'(cpu_err), 32'h1);
        check("miss_rdata", cpu_rdata, 32'h0);
        cpu_req = 1'b0; slv_ready = '0;
        cycle(1);

        // Timeout on slave 4, then an immediate access to slave 5
        start_req(32'h2000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF);
        cycle(1);
        check("to_sel_c1", 32'(slv_sel), 32'h10);
        check("to_addr", slv_addr, 32'h10);
        cycle(3);
        check("to_sel_c4", 32'(slv_sel), 32'h10);
        check("to_ready_c4", 32'(cpu_ready), 32'h0);
        cycle(1);
        check("to_sel_drop", 32'(slv_sel), 32'h0);
        check("to_ready", 32'(cpu_ready), 32'h1);
        check("to_err", 32'(cpu_err), 32'h1);
        check("to_rdata", cpu_rdata, 32'hDEAD_BEEF);
        slv_ready = 6'b100000;
        set_rdata(5, 32'h55AA_1234);
        start_req(32'h3000_0004, 1'b0, 32'h0, 32'h55AA_1234);
        cycle(1);
        check("b2b_ignored_in_resp", 32'(slv_sel), 32'h0);
        cycle(1);
        check("b2b_sel", 32'(slv_sel), 32'h20);
        check("b2b_addr", slv_addr, 32'h4);
        cycle(1);
        check("b2b_ready", 32'(cpu_ready), 32'h1);
        check("b2b_err", 32'(cpu_err), 32'h0);
        cpu_req = 1'b0; slv_ready = '0;
        cycle(1);

        // Overlap (windows 1 and 3) and ready on the timeout cycle
        slv_ready = 6'b001000;
        set_rdata(1, 32'h1111_2222);
        set_rdata(3, 32'h3333_4444);
        start_req(32'h1000_0020, 1'b0, 32'h0, 32'h1111_2222);
        cycle(1);
        check("ov_sel", 32'(slv_sel), 32'h02);
        check("ov_addr", slv_addr, 32'h20);
        cycle(3);
        check("ov_sel_c4", 32'(slv_sel), 32'h02);
        slv_ready = 6'b001010;
        cycle(1);
        check("tie_ready", 32'(cpu_ready), 32'h1);
        check("tie_err", 32'(cpu_err), 32'h0);
        check("tie_rdata", cpu_rdata, 32'h1111_2222);
        cpu_req = 1'b0; slv_ready = '0;
        cycle(1);

        // Reset while in ACCESS
        start_req(32'h0000_4ABC, 1'b0, 32'h0, 32'hCAFE_F00D);
        cycle(1);
        check("rm_sel", 32'(slv_sel), 32'h01);
        void'(exp_q.pop_back());
        ready_cnt = 0;
        rst_n = 1'b0; cpu_req = 1'b0;
        cycle(1);
        check_idle_outputs("rm");
        rst_n = 1'b1;
        cycle(3);
        check("rm_no_pulse", 32'(ready_cnt), 32'd0);
        slv_ready = 6'b000001;
        set_rdata(0, 32'hCAFE_F00D);
        start_req(32'h0000_4ABC, 1'b0, 32'h0, 32'hCAFE_F00D);
        cycle(1);
        check("rm2_addr", slv_addr, 32'hABC);
        cycle(1);
        check("rm2_ready", 32'(cpu_ready), 32'h1);
        check("rm2_rdata", cpu_rdata, 32'hCAFE_F00D);
        cpu_req = 1'b0; slv_ready = '0;
        cycle(2);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
